// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port unified-memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} mem_arb_state_t;
    typedef enum logic {PORT_IF, PORT_D} mem_arb_port_t;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way picker (IF vs D).
// MEM_ARB_DATA_PRIO_EN selects fixed D priority instead of round-robin.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic          req_if_i,
    input  logic          req_d_i,
    input  mem_arb_port_t last_i,
    output mem_arb_port_t win_o
);

`ifdef MEM_ARB_DATA_PRIO_EN
    logic unused_last;
    assign unused_last = last_i;
`endif

    always_comb begin
        win_o = PORT_IF;
        if (req_if_i && req_d_i) begin
`ifdef MEM_ARB_DATA_PRIO_EN
            win_o = PORT_D;
`else
            // Tie goes to whichever port was not served last.
            win_o = (last_i == PORT_D) ? PORT_IF : PORT_D;
`endif
        end else if (req_d_i) begin
            win_o = PORT_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter/sequencer for the single-port unified memory: IDLE -> ACCESS -> RESP.
// Build option MEM_ARB_DATA_PRIO_EN: D wins every tie, no last-grant flag.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_if_i,
    input  logic [ADDR_W-1:0] addr_if_i32,
    output logic [DATA_W-1:0] rdata_if_o32,
    output logic              ack_if_o,
    input  logic              req_d_i,
    input  logic              we_d_i,
    input  logic [ADDR_W-1:0] addr_d_i32,
    input  logic [DATA_W-1:0] wdata_d_i32,
    output logic [DATA_W-1:0] rdata_d_o32,
    output logic              ack_d_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o32,
    output logic [DATA_W-1:0] mem_wdata_o32,
    input  logic [DATA_W-1:0] mem_rdata_i32
);

    mem_arb_state_t    state_q, state_d;
    mem_arb_port_t     grant_q, grant_d;
    mem_arb_port_t     win, last_grant;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_if_q, rdata_if_d;
    logic [DATA_W-1:0] rdata_d_q, rdata_d_d;
    logic              ack_if_q, ack_if_d;
    logic              ack_d_q, ack_d_d;

`ifdef MEM_ARB_DATA_PRIO_EN
    assign last_grant = PORT_D;
`else
    mem_arb_port_t last_q, last_d;
    assign last_grant = last_q;
`endif

    rr_arb2 u_arb (
        .req_if_i (req_if_i),
        .req_d_i  (req_d_i),
        .last_i   (last_grant),
        .win_o    (win)
    );

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        rdata_if_d = rdata_if_q;
        rdata_d_d  = rdata_d_q;
        ack_if_d   = 1'b0;
        ack_d_d    = 1'b0;
`ifndef MEM_ARB_DATA_PRIO_EN
        last_d     = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_if_i || req_d_i) begin
                    state_d = ACCESS;
                    grant_d = win;
`ifndef MEM_ARB_DATA_PRIO_EN
                    last_d  = win;
`endif
                    if (win == PORT_D) begin
                        addr_d  = addr_d_i32;
                        we_d    = we_d_i;
                        wdata_d = wdata_d_i32;
                    end else begin
                        addr_d  = addr_if_i32;
                        we_d    = 1'b0;
                    end
                end
            end
            ACCESS: begin
                // Memory read is combinational, so a write captures the old word here.
                state_d = RESP;
                if (grant_q == PORT_D) begin
                    rdata_d_d = mem_rdata_i32;
                    ack_d_d   = 1'b1;
                end else begin
                    rdata_if_d = mem_rdata_i32;
                    ack_if_d   = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            grant_q    <= PORT_IF;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            rdata_if_q <= '0;
            rdata_d_q  <= '0;
            ack_if_q   <= 1'b0;
            ack_d_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            rdata_if_q <= rdata_if_d;
            rdata_d_q  <= rdata_d_d;
            ack_if_q   <= ack_if_d;
            ack_d_q    <= ack_d_d;
        end
    end

`ifndef MEM_ARB_DATA_PRIO_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) last_q <= PORT_D;
        else         last_q <= last_d;
    end
`endif

    // Gating by state makes an async reset mid-ACCESS drop the write at once.
    assign mem_we_o      = we_q & (state_q == ACCESS);
    assign mem_addr_o32  = addr_q;
    assign mem_wdata_o32 = wdata_q;
    assign rdata_if_o32  = rdata_if_q;
    assign rdata_d_o32   = rdata_d_q;
    assign ack_if_o      = ack_if_q;
    assign ack_d_o       = ack_d_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-level schedule model.
module tb_mem_arbiter;

    logic        clk, rst_ni;
    logic        req_if, req_d, we_d;
    logic [31:0] addr_if, addr_d, wdata_d;
    logic [31:0] rdata_if, rdata_d, mem_addr, mem_wdata, mem_rdata;
    logic        ack_if, ack_d, mem_we;

    mem_arbiter dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .req_if_i(req_if), .addr_if_i32(addr_if), .rdata_if_o32(rdata_if), .ack_if_o(ack_if),
        .req_d_i(req_d), .we_d_i(we_d), .addr_d_i32(addr_d), .wdata_d_i32(wdata_d),
        .rdata_d_o32(rdata_d), .ack_d_o(ack_d),
        .mem_we_o(mem_we), .mem_addr_o32(mem_addr), .mem_wdata_o32(mem_wdata),
        .mem_rdata_i32(mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Environment memory (64 words) and the bench's reference copy.
    logic [31:0] mem [64];
    logic [31:0] ref_mem [64];
    assign mem_rdata = mem[mem_addr[7:2]];
    always @(posedge clk) if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Schedule model: a grant sampled at edge g drives ACCESS after g, acks after g+1,
    // and the arbiter can sample again at edge g+3.
    int          e = 0, free_e = 0, acc_e = -1, ack_e = -1;
    logic        last_d = 1'b1;
    logic        gr_port, gr_we;
    logic [31:0] gr_addr, gr_wdata;
    logic [31:0] rd_if_exp = '0, rd_d_exp = '0;
    int          mode = 0, we_hi_cnt = 0;
    logic        seen_if, seen_d;

    task automatic new_if();
        req_if = 1'b1; addr_if = $urandom;
    endtask

    task automatic new_d();
        req_d = 1'b1; we_d = 1'($urandom_range(0, 1)); addr_d = $urandom; wdata_d = $urandom;
    endtask

    task automatic model_reset();
        free_e = 0; acc_e = -1; ack_e = -1; last_d = 1'b1;
        rd_if_exp = '0; rd_d_exp = '0;
    endtask

    task automatic step();
        logic win;
        e++;
        if (e >= free_e && (req_if || req_d)) begin
            if (req_if && req_d) begin
`ifdef MEM_ARB_DATA_PRIO_EN
                win = 1'b1;
`else
                win = !last_d;
`endif
            end else begin
                win = req_d;
            end
            last_d = win; gr_port = win;
            gr_addr = win ? addr_d : addr_if; gr_we = win ? we_d : 1'b0; gr_wdata = wdata_d;
            acc_e = e; ack_e = e + 1; free_e = e + 3;
        end
        if (e == ack_e) begin
            if (gr_port) rd_d_exp = ref_mem[gr_addr[7:2]];
            else         rd_if_exp = ref_mem[gr_addr[7:2]];
            if (gr_we) ref_mem[gr_addr[7:2]] = gr_wdata;
        end
        @(posedge clk); #1;
        chk("ack_if", 64'(ack_if), 64'((e == ack_e) && !gr_port));
        chk("ack_d", 64'(ack_d), 64'((e == ack_e) && gr_port));
        chk("rdata_if", 64'(rdata_if), 64'(rd_if_exp));
        chk("rdata_d", 64'(rdata_d), 64'(rd_d_exp));
        chk("mem_we", 64'(mem_we), 64'((e == acc_e) && gr_we));
        if (e == acc_e) begin
            chk("mem_addr", 64'(mem_addr), 64'(gr_addr));
            if (gr_we) chk("mem_wdata", 64'(mem_wdata), 64'(gr_wdata));
        end
        if (mem_we) we_hi_cnt++;
        seen_if = ack_if; seen_d = ack_d;
        if (seen_if) req_if = 1'b0;
        if (seen_d)  req_d  = 1'b0;
        if (mode == 2) begin
            if (!req_if) new_if();
            if (!req_d)  new_d();
        end else if (mode == 1) begin
            if (!req_if && $urandom_range(0, 1) == 1) new_if();
            if (!req_d  && $urandom_range(0, 1) == 1) new_d();
        end
    endtask

    task automatic wait_ack(input logic port, output int at);
        at = -1;
        for (int k = 0; k < 20; k++) begin
            step();
            if (port ? seen_d : seen_if) begin
                at = e;
                return;
            end
        end
        chk("ack_timeout", 64'(0), 64'(1));
    endtask

    task automatic do_reset();
        req_if = 1'b0; req_d = 1'b0;
        rst_ni = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_ni = 1'b1;
        model_reset();
    endtask

    task automatic chk_zero_outs(input string tag);
        chk({tag, "_ack_if"}, 64'(ack_if), 64'(0));
        chk({tag, "_ack_d"}, 64'(ack_d), 64'(0));
        chk({tag, "_rdata_if"}, 64'(rdata_if), 64'(0));
        chk({tag, "_rdata_d"}, 64'(rdata_d), 64'(0));
        chk({tag, "_mem_we"}, 64'(mem_we), 64'(0));
        chk({tag, "_mem_addr"}, 64'(mem_addr), 64'(0));
        chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'(0));
    endtask

    initial begin
        int t0, t1, prev, nack;
        logic exp_port;
        rst_ni = 1'b0; req_if = 1'b0; req_d = 1'b0; we_d = 1'b0;
        addr_if = '0; addr_d = '0; wdata_d = '0;
        for (int i = 0; i < 64; i++) begin
            mem[i] = $urandom; ref_mem[i] = mem[i];
        end
        mem[1] = 32'hDEADBEEF; ref_mem[1] = 32'hDEADBEEF;
        #12 chk_zero_outs("reset");
        @(posedge clk); #1 rst_ni = 1'b1;

        // IF read of 0x04: ack two edges after the grant.
        req_if = 1'b1; addr_if = 32'h4;
        we_hi_cnt = 0;
        wait_ack(1'b0, t1);
        chk("if_latency", 64'(t1), 64'(2));
        chk("if_rdata", 64'(rdata_if), 64'(32'hDEADBEEF));
        chk("if_no_we", 64'(we_hi_cnt), 64'(0));
        repeat (3) step();

        // D write then read of 0x08.
        we_hi_cnt = 0;
        req_d = 1'b1; we_d = 1'b1; addr_d = 32'h8; wdata_d = 32'h12345678;
        wait_ack(1'b1, t1);
        chk("wr_we_cycles", 64'(we_hi_cnt), 64'(1));
        req_d = 1'b1; we_d = 1'b0; addr_d = 32'h8;
        wait_ack(1'b1, t1);
        chk("rd_back", 64'(rdata_d), 64'(32'h12345678));
        repeat (3) step();

        // Both ports continuously requesting.
        do_reset();
        mode = 2; new_if(); new_d();
        prev = -1; nack = 0;
        repeat (14) begin
            step();
            if (seen_if || seen_d) begin
`ifdef MEM_ARB_DATA_PRIO_EN
                exp_port = 1'b1;
`else
                exp_port = nack[0];
`endif
                chk("cont_port", 64'(seen_d), 64'(exp_port));
                if (prev >= 0) chk("cont_gap", 64'(e - prev), 64'(3));
                prev = e; nack++;
            end
        end
        mode = 0;
        repeat (12) step();

        // D alone, IF rises during D's ACCESS.
        req_d = 1'b1; we_d = 1'b0; addr_d = 32'h20;
        step();
        new_if();
        wait_ack(1'b1, t0);
        wait_ack(1'b0, t1);
        chk("late_if_gap", 64'(t1 - t0), 64'(3));
        repeat (3) step();

        // Async reset during the ACCESS of a D write to 0x10.
        mem[4] = 32'hA5A50010; ref_mem[4] = 32'hA5A50010;
        req_d = 1'b1; we_d = 1'b1; addr_d = 32'h10; wdata_d = 32'hFFFF0000;
        step();
        chk("pre_rst_we", 64'(mem_we), 64'(1));
        rst_ni = 1'b0; req_d = 1'b0;
        #1 chk_zero_outs("midrst");
        repeat (2) @(posedge clk);
        #1 rst_ni = 1'b1;
        model_reset();
        chk("midrst_word", 64'(mem[4]), 64'(32'hA5A50010));
        repeat (4) step();

        // Random traffic.
        mode = 1;
        repeat (400) step();
        mode = 0;
        repeat (12) step();
        for (int i = 0; i < 64; i++) chk("final_mem", 64'(mem[i]), 64'(ref_mem[i]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer for the single-port word-addressed unified memory in the multicycle processor. Requests come from the instruction-fetch (IF) port and the data (D) port. The block grants one requester at a time, drives the memory for one access cycle, registers the read data, and returns a one-cycle acknowledge. It sits between the control/datapath and the memory, and replaces direct datapath-to-memory wiring.

## Interface
- `ADDR_W`, 32, address width on every port.
- `DATA_W`, 32, data width on every port.

- `clk_i`  in  1  single clock; all state changes on rising edge.
- `rst_ni`  in  1  asynchronous reset, active-low.
- `req_if_i`  in  1  IF request; read-only.
- `addr_if_i32`  in  ADDR_W  IF byte address.
- `rdata_if_o32`  out  DATA_W  IF read data; valid while `ack_if_o` is high.
- `ack_if_o`  out  1  IF acknowledge pulse.
- `req_d_i`  in  1  D request.
- `we_d_i`  in  1  D write enable; 1 = write, 0 = read.
- `addr_d_i32`  in  ADDR_W  D byte address.
- `wdata_d_i32`  in  DATA_W  D write data.
- `rdata_d_o32`  out  DATA_W  D read data; valid while `ack_d_o` is high.
- `ack_d_o`  out  1  D acknowledge pulse.
- `mem_we_o`  out  1  memory write enable.
- `mem_addr_o32`  out  ADDR_W  memory address.
- `mem_wdata_o32`  out  DATA_W  memory write data.
- `mem_rdata_i32`  in  DATA_W  memory read data; combinational read of `mem_addr_o32`.

## Operation
- FSM states: IDLE, ACCESS, RESP. Transitions: IDLE -> ACCESS on any request; ACCESS -> RESP always; RESP -> IDLE always.
- Requests are sampled only in IDLE.
- On a grant, the block registers the winner's addr/we/wdata into `mem_addr_o32`/`mem_we_q`/`mem_wdata_o32`. For IF, the write enable is forced to 0.
- `mem_we_o = mem_we_q & (state == ACCESS)`. A write is therefore exactly one cycle long and is committed at the ACCESS->RESP edge.
- At the end of ACCESS, `mem_rdata_i32` is captured into the winner's rdata register. For a D write, the captured value is the pre-write word.
- In RESP, the winner's ack is 1 for exactly one cycle. The loser's ack and rdata are unchanged.
- Requester rules:
  - Hold req, addr, we and wdata stable from assertion until ack.
  - In the cycle after ack, either deassert req or present a new request.
- Arbitration: if only one port requests, that port wins. If both request, the port not granted last wins (round-robin).
- The last-grant flag resets to D, so IF wins the first tie.
- `addr[1:0]` is forwarded unchanged. The memory ignores it, so no alignment check is made.

## Timing
- Reset values: state IDLE, both acks 0, both rdata 0, `mem_we_o` 0, `mem_addr_o32` 0, `mem_wdata_o32` 0, last-grant flag = D.
- Latency: a request seen in IDLE at cycle N gets ACCESS at N+1 and ack at N+2. Back-to-back accesses from one port occur every 3 cycles at best.
- With both ports continuously requesting, grants alternate IF, D, IF, and so on.
- Reset mid-operation: reset asserted during ACCESS forces state IDLE asynchronously. `mem_we_o` drops immediately, the write is not committed, and no ack is issued.
- A request that arrives during ACCESS or RESP waits. It is sampled in the next IDLE.

## Configuration
- `MEM_ARB_DATA_PRIO_EN`
  - Defined: fixed priority, D always wins a tie. The last-grant flag is not implemented.
  - Undefined: round-robin as specified above.

## Structure
- Package `mem_arb_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, ACCESS, RESP} mem_arb_state_t`
  - `typedef enum logic {PORT_IF, PORT_D} mem_arb_port_t`
- Sub-module `rr_arb2`: combinational 2-way picker.
  - Inputs: two requests, last grant.
  - Output: winner.
  - Holds the `MEM_ARB_DATA_PRIO_EN` switch.

## Test plan
- Reset, then IF read at 0x04 with memory word 0xDEADBEEF: `ack_if_o` is 1 two cycles later, `rdata_if_o32` = 0xDEADBEEF, and `mem_we_o` stays 0 throughout.
- D write of 0x12345678 to 0x08, then D read of 0x08: `mem_we_o` is high for exactly one cycle, and the read returns 0x12345678.
- Both ports request continuously: grants go IF, D, IF, D, with acks 3 cycles apart. With `MEM_ARB_DATA_PRIO_EN` defined, D is granted every time.
- D requests alone, then IF rises during ACCESS: D is acked first, and IF is granted in the following IDLE.
- `rst_ni` pulses low during the ACCESS of a D write to 0x10: `mem_we_o` falls immediately, no ack is issued, word 0x10 is unchanged, and all outputs are 0.
